iic_reg_seq: RTL and testbench

//  Register-level IIC sequencer feeding the fabric operation FIFO in front of the IIC arbiter.

---
 rtl/iic_reg_seq_pkg.sv | 33 +++
 rtl/iic_reg_seq.sv | 158 +++++++++++++++
 tb/tb_iic_reg_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/iic_reg_seq_pkg.sv
// rtl/iic_reg_seq_pkg.sv - op word field positions, sequencer states and op word builder
package iic_reg_seq_pkg;

    localparam int   OP_LOCK  = 11;
    localparam int   OP_STOP  = 10;
    localparam int   OP_START = 9;
    localparam int   OP_RNW   = 8;
    localparam logic IIC_RD   = 1'b1;
    localparam logic IIC_WR   = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEV_W,
        ST_REG,
        ST_WDATA,
        ST_DEV_R,
        ST_RDATA,
        ST_RX_WAIT
    } state_t;

    function automatic logic [11:0] make_op(input logic lock, input logic stop,
                                            input logic start, input logic rnw,
                                            input logic [7:0] data);
        logic [11:0] w;
        w           = {4'b0000, data};
        w[OP_LOCK]  = lock;
        w[OP_STOP]  = stop;
        w[OP_START] = start;
        w[OP_RNW]   = rnw;
        return w;
    endfunction

endpackage

// File: rtl/iic_reg_seq.sv
// rtl/iic_reg_seq.sv - register read/write request to locked IIC op words, read byte reassembly
module iic_reg_seq
    import iic_reg_seq_pkg::*;
#(
    parameter  int DATA_BYTES = 2,
    parameter  int RX_TIMEOUT = 4096,
    localparam int LW         = $clog2(DATA_BYTES + 1),
    localparam int DW         = 8 * DATA_BYTES
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_rnw,
    input  logic [6:0]    req_dev_addr,
    input  logic [7:0]    req_reg_addr,
    input  logic [LW-1:0] req_len,
    input  logic [DW-1:0] req_wr_data,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [11:0]   op_data,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          resp_valid,
    output logic [DW-1:0] resp_data,
    output logic          resp_err,
    output logic          busy
);

    localparam int TW = $clog2(RX_TIMEOUT);

    state_t        state, state_n;
    logic          rnw_q;
    logic [6:0]    dev_q;
    logic [7:0]    reg_q;
    logic [LW-1:0] len_q, len_norm, idx_q, rx_cnt;
    logic [DW-1:0] wr_q, rx_shift, wr_sel, resp_fill;
    logic [TW-1:0] tmo_q;
    logic          accept, last, rx_take, rx_done, rx_tmo;

    always_comb begin
        len_norm = req_len;
        if (req_len == '0)
            len_norm = LW'(1);
        else if (req_len > LW'(DATA_BYTES))
            len_norm = LW'(DATA_BYTES);
    end

    assign accept  = req_valid && req_ready;
    assign last    = (idx_q == len_q - LW'(1));
    assign busy    = (state != ST_IDLE);
    // Bytes count from DEV_R acceptance on, so they may arrive while RDATA words are still issuing.
    assign rx_take = ((state == ST_RDATA) || (state == ST_RX_WAIT)) && rx_valid && (rx_cnt < len_q);
    assign rx_done = (state == ST_RX_WAIT) && (rx_cnt == len_q);
    assign rx_tmo  = (state == ST_RX_WAIT) && !rx_done && !rx_take && (tmo_q == TW'(RX_TIMEOUT - 1));

    // MS byte goes out first; a short (timed-out) read is left-aligned within len bytes.
    assign wr_sel    = wr_q >> (8 * (int'(len_q) - int'(idx_q) - 1));
    assign resp_fill = rx_shift << (8 * (int'(len_q) - int'(rx_cnt)));

    always_comb begin
        state_n  = state;
        op_valid = 1'b0;
        op_data  = '0;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_n = ST_DEV_W;
            end
            ST_DEV_W: begin
                op_valid = 1'b1;
                op_data  = make_op(1'b1, 1'b0, 1'b1, IIC_WR, {dev_q, IIC_WR});
                if (op_ready)
                    state_n = ST_REG;
            end
            ST_REG: begin
                op_valid = 1'b1;
                op_data  = make_op(1'b1, 1'b0, 1'b0, IIC_WR, reg_q);
                if (op_ready)
                    state_n = rnw_q ? ST_DEV_R : ST_WDATA;
            end
            ST_WDATA: begin
                op_valid = 1'b1;
                op_data  = make_op(!last, last, 1'b0, IIC_WR, wr_sel[7:0]);
                if (op_ready && last)
                    state_n = ST_IDLE;
            end
            ST_DEV_R: begin
                op_valid = 1'b1;
                op_data  = make_op(1'b1, 1'b0, 1'b1, IIC_RD, {dev_q, IIC_RD});
                if (op_ready)
                    state_n = ST_RDATA;
            end
            ST_RDATA: begin
                op_valid = 1'b1;
                op_data  = make_op(!last, last, 1'b0, IIC_RD, 8'h00);
                if (op_ready && last)
                    state_n = ST_RX_WAIT;
            end
            ST_RX_WAIT: begin
                if (rx_done || rx_tmo)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b0;
            rnw_q      <= 1'b0;
            dev_q      <= '0;
            reg_q      <= '0;
            len_q      <= '0;
            wr_q       <= '0;
            idx_q      <= '0;
            rx_cnt     <= '0;
            rx_shift   <= '0;
            tmo_q      <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
        end else begin
            state      <= state_n;
            req_ready  <= (state_n == ST_IDLE);
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            if (accept) begin
                rnw_q    <= req_rnw;
                dev_q    <= req_dev_addr;
                reg_q    <= req_reg_addr;
                len_q    <= len_norm;
                wr_q     <= req_wr_data;
                rx_cnt   <= '0;
                rx_shift <= '0;
            end
            if ((state == ST_REG) || (state == ST_DEV_R))
                idx_q <= '0;
            else if (((state == ST_WDATA) || (state == ST_RDATA)) && op_ready)
                idx_q <= idx_q + LW'(1);
            if (rx_take) begin
                rx_shift <= (rx_shift << 8) | DW'(rx_data);
                rx_cnt   <= rx_cnt + LW'(1);
            end
            if ((state != ST_RX_WAIT) || rx_take)
                tmo_q <= '0;
            else
                tmo_q <= tmo_q + TW'(1);
            if (rx_done || rx_tmo) begin
                resp_valid <= 1'b1;
                resp_err   <= rx_tmo;
                resp_data  <= resp_fill;
            end
        end
    end

endmodule

// File: tb/tb_iic_reg_seq.sv
// tb/tb_iic_reg_seq.sv - directed self-checking bench for iic_reg_seq
module tb_iic_reg_seq;

    localparam int DB  = 2;
    localparam int RXT = 100;
    localparam int LW  = $clog2(DB + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_rnw;
    logic [6:0]    req_dev_addr;
    logic [7:0]    req_reg_addr;
    logic [LW-1:0] req_len;
    logic [8*DB-1:0] req_wr_data;
    logic          op_valid;
    logic          op_ready;
    logic [11:0]   op_data;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          resp_valid;
    logic [8*DB-1:0] resp_data;
    logic          resp_err;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    iic_reg_seq #(.DATA_BYTES(DB), .RX_TIMEOUT(RXT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
        .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr),
        .req_len(req_len), .req_wr_data(req_wr_data),
        .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                            input logic [LW-1:0] len, input logic [8*DB-1:0] wd);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check("req_ready_wait", req_ready, 1'b1);
        req_rnw      = rnw;
        req_dev_addr = dev;
        req_reg_addr = rg;
        req_len      = len;
        req_wr_data  = wd;
        req_valid    = 1'b1;
        tick();
        req_valid    = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [11:0] exp);
        check({tag, "_valid"}, op_valid, 1'b1);
        check(tag, op_data, exp);
        tick();
    endtask

    task automatic wait_resp(input string tag, input int max, input logic [8*DB-1:0] exp_data,
                             input logic exp_err);
        int n;
        n = 0;
        while (!resp_valid && n < max) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, resp_valid, 1'b1);
        check({tag, "_data"}, resp_data, exp_data);
        check({tag, "_err"}, resp_err, exp_err);
        tick();
        check({tag, "_pulse"}, resp_valid, 1'b0);
    endtask

    initial begin
        logic [11:0] got [$];
        logic [11:0] prev;
        logic        stalled;
        rst_n = 1'b1;
        req_valid = 1'b0; req_rnw = 1'b0; req_dev_addr = '0; req_reg_addr = '0;
        req_len = '0; req_wr_data = '0; op_ready = 1'b1; rx_valid = 1'b0; rx_data = '0;
        #1 rst_n = 1'b0;
        #3;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_op_valid", op_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        check("rel_req_ready_low", req_ready, 1'b0);
        tick();
        check("rel_req_ready_high", req_ready, 1'b1);

        // Write len=2: words T+1..T+4, req_ready back at T+5.
        send_req(1'b0, 7'h48, 8'h05, 2'd2, 16'h1234);
        expect_word("wr_dev", 12'hA90);
        expect_word("wr_reg", 12'h805);
        expect_word("wr_d0", 12'h812);
        expect_word("wr_d1", 12'h434);
        check("wr_done_ready", req_ready, 1'b1);
        check("wr_done_op_valid", op_valid, 1'b0);
        check("wr_done_busy", busy, 1'b0);
        check("wr_no_resp", resp_valid, 1'b0);

        // Read len=2; first byte overlaps RDATA issue.
        send_req(1'b1, 7'h48, 8'h00, 2'd2, 16'h0000);
        expect_word("rd_dev_w", 12'hA90);
        expect_word("rd_reg", 12'h800);
        expect_word("rd_dev_r", 12'hB91);
        rx_valid = 1'b1; rx_data = 8'hAB;
        expect_word("rd_d0", 12'h900);
        rx_valid = 1'b0;
        expect_word("rd_d1", 12'h500);
        check("rd_busy_wait", busy, 1'b1);
        rx_valid = 1'b1; rx_data = 8'hCD;
        tick();
        rx_valid = 1'b0;
        wait_resp("rd_resp", 20, 16'hABCD, 1'b0);

        // Write len=1 under op_ready stalls.
        send_req(1'b0, 7'h48, 8'h07, 2'd1, 16'h005A);
        stalled = 1'b0;
        prev = '0;
        for (int c = 0; c < 10; c++) begin
            op_ready = (c == 1 || c == 2) ? 1'b0 : 1'b1;
            if (stalled) begin
                check("stall_valid_hold", op_valid, 1'b1);
                check("stall_data_hold", op_data, prev);
            end
            if (op_valid && op_ready)
                got.push_back(op_data);
            stalled = op_valid && !op_ready;
            prev    = op_data;
            tick();
        end
        op_ready = 1'b1;
        check("stall_count", got.size(), 3);
        if (got.size() == 3) begin
            check("stall_w0", got[0], 12'hA90);
            check("stall_w1", got[1], 12'h807);
            check("stall_w2", got[2], 12'h45A);
        end

        // Read len=2 with a single byte: timeout, partial data left-aligned.
        send_req(1'b1, 7'h48, 8'h00, 2'd2, 16'h0000);
        expect_word("to_dev_w", 12'hA90);
        expect_word("to_reg", 12'h800);
        expect_word("to_dev_r", 12'hB91);
        expect_word("to_d0", 12'h900);
        expect_word("to_d1", 12'h500);
        rx_valid = 1'b1; rx_data = 8'h11;
        tick();
        rx_valid = 1'b0;
        wait_resp("to_resp", RXT + 20, 16'h1100, 1'b1);

        // Stray rx bytes in IDLE and during a write are ignored.
        rx_valid = 1'b1; rx_data = 8'hEE;
        tick();
        rx_data = 8'h77;
        send_req(1'b0, 7'h48, 8'h05, 2'd2, 16'h1234);
        expect_word("st_wr_dev", 12'hA90);
        expect_word("st_wr_reg", 12'h805);
        expect_word("st_wr_d0", 12'h812);
        expect_word("st_wr_d1", 12'h434);
        rx_valid = 1'b0;
        check("st_wr_no_resp", resp_valid, 1'b0);
        send_req(1'b1, 7'h21, 8'h33, 2'd1, 16'h0000);
        expect_word("st_rd_dev_w", 12'hA42);
        expect_word("st_rd_reg", 12'h833);
        expect_word("st_rd_dev_r", 12'hB43);
        expect_word("st_rd_d0", 12'h500);
        rx_valid = 1'b1; rx_data = 8'h5C;
        tick();
        rx_data = 8'h99;
        tick();
        rx_valid = 1'b0;
        wait_resp("st_rd_resp", 20, 16'h005C, 1'b0);

        // Reset during the REG word of a read aborts at once.
        send_req(1'b1, 7'h48, 8'h00, 2'd2, 16'h0000);
        expect_word("ab_dev_w", 12'hA90);
        check("ab_reg", op_data, 12'h800);
        rst_n = 1'b0;
        #1;
        check("ab_op_valid", op_valid, 1'b0);
        check("ab_busy", busy, 1'b0);
        check("ab_req_ready", req_ready, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        check("ab_ready_back", req_ready, 1'b1);

        // len=0 is treated as 1; len above DATA_BYTES is clamped.
        send_req(1'b0, 7'h48, 8'h05, 2'd0, 16'h00AB);
        expect_word("l0_dev", 12'hA90);
        expect_word("l0_reg", 12'h805);
        expect_word("l0_d0", 12'h4AB);
        check("l0_idle", busy, 1'b0);
        send_req(1'b0, 7'h48, 8'h05, 2'd3, 16'hBEEF);
        expect_word("l3_dev", 12'hA90);
        expect_word("l3_reg", 12'h805);
        expect_word("l3_d0", 12'h8BE);
        expect_word("l3_d1", 12'h4EF);
        check("l3_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
